tlb_mmu_unit: RTL and testbench

Parametrised joint TLB for the MIPS CPU, placed beside CP0 in the write-back stage. It serves two combinational translation ports: port 0 for instruction fetch and port 1 for data access. It also executes TLBP, TLBR, TLBWI and TLBWR through a small handshaked operation FSM. A CP0 Random counter bounded by Wired drives TLBWR, and reset clears every entry's valid bits.

---
 rtl/tlb_mmu_unit.sv | 197 +++++++++++++++++++
 tb/tb_tlb_mmu_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_mmu_unit.sv
// Joint instruction/data TLB beside CP0: two combinational search ports plus a
// small handshaked FSM running TLBP/TLBR/TLBWI/TLBWR, with the Random counter.
module tlb_mmu_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [18:0]     s0_vpn2,
  input  logic            s0_odd_page,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_pfn,
  output logic [2:0]      s0_c,
  output logic            s0_d,
  output logic            s0_v,
  input  logic [18:0]     s1_vpn2,
  input  logic            s1_odd_page,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_pfn,
  output logic [2:0]      s1_c,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            op_valid,
  input  logic [1:0]      op_code,
  output logic            op_ready,
  output logic            op_done,
  input  logic [31:0]     c0_entryhi,
  input  logic [31:0]     c0_entrylo0,
  input  logic [31:0]     c0_entrylo1,
  input  logic [IDXW-1:0] c0_index,
  input  logic [IDXW-1:0] c0_wired,
  input  logic            wired_we,
  output logic            p_found,
  output logic [IDXW-1:0] p_index,
  output logic [31:0]     r_entryhi,
  output logic [31:0]     r_entrylo0,
  output logic [31:0]     r_entrylo1,
  output logic [IDXW-1:0] random_index
);

  typedef enum logic [1:0] {S_IDLE, S_PCMP, S_DONE} state_t;

  logic [18:0]       r_vpn2 [TLBNUM];
  logic [7:0]        r_asid [TLBNUM];
  logic [19:0]       r_pfn0 [TLBNUM];
  logic [19:0]       r_pfn1 [TLBNUM];
  logic [2:0]        r_c0   [TLBNUM];
  logic [2:0]        r_c1   [TLBNUM];
  logic [TLBNUM-1:0] r_g, r_d0, r_d1, r_v0, r_v1;

  state_t            r_state, w_state_next;
  logic              w_we, w_rd, w_probe;
  logic [IDXW-1:0]   w_widx;
  logic [18:0]       r_probe_vpn2;
  logic [7:0]        r_probe_asid;
  logic [IDXW-1:0]   r_random;
  logic [TLBNUM-1:0] w_hit0, w_hit1, w_hitp;
  logic [IDXW:0]     w_sel0, w_sel1, w_selp;
  logic [IDXW-1:0]   w_idx0, w_idx1;
  logic              w_unused;

  assign w_unused = ^{c0_entryhi[12:8], c0_entrylo0[31:26], c0_entrylo1[31:26]};

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
    assign w_hit0[gi] = (r_vpn2[gi] == s0_vpn2) && (r_g[gi] || r_asid[gi] == c0_entryhi[7:0]);
    assign w_hit1[gi] = (r_vpn2[gi] == s1_vpn2) && (r_g[gi] || r_asid[gi] == c0_entryhi[7:0]);
    assign w_hitp[gi] = (r_vpn2[gi] == r_probe_vpn2) && (r_g[gi] || r_asid[gi] == r_probe_asid);
  end

  // Returns {found, index}; scanning downwards lets the lowest hit win.
  function automatic logic [IDXW:0] f_first(input logic [TLBNUM-1:0] hits);
    logic [IDXW:0] res;
    res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (hits[i]) res = {1'b1, IDXW'(i)};
    return res;
  endfunction

  assign w_sel0 = f_first(w_hit0);
  assign w_sel1 = f_first(w_hit1);
  assign w_selp = f_first(w_hitp);
  assign w_idx0 = w_sel0[IDXW-1:0];
  assign w_idx1 = w_sel1[IDXW-1:0];

  assign s0_found = w_sel0[IDXW];
  assign s0_index = w_idx0;
  assign s0_pfn   = !s0_found ? 20'd0 : (s0_odd_page ? r_pfn1[w_idx0] : r_pfn0[w_idx0]);
  assign s0_c     = !s0_found ? 3'd0  : (s0_odd_page ? r_c1[w_idx0]   : r_c0[w_idx0]);
  assign s0_d     = s0_found && (s0_odd_page ? r_d1[w_idx0] : r_d0[w_idx0]);
  assign s0_v     = s0_found && (s0_odd_page ? r_v1[w_idx0] : r_v0[w_idx0]);

  assign s1_found = w_sel1[IDXW];
  assign s1_index = w_idx1;
  assign s1_pfn   = !s1_found ? 20'd0 : (s1_odd_page ? r_pfn1[w_idx1] : r_pfn0[w_idx1]);
  assign s1_c     = !s1_found ? 3'd0  : (s1_odd_page ? r_c1[w_idx1]   : r_c0[w_idx1]);
  assign s1_d     = s1_found && (s1_odd_page ? r_d1[w_idx1] : r_d0[w_idx1]);
  assign s1_v     = s1_found && (s1_odd_page ? r_v1[w_idx1] : r_v0[w_idx1]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    op_ready     = 1'b0;
    op_done      = 1'b0;
    w_we         = 1'b0;
    w_rd         = 1'b0;
    w_probe      = 1'b0;
    w_widx       = c0_index;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          w_state_next = S_DONE;
          case (op_code)
            2'b00: begin w_probe = 1'b1; w_state_next = S_PCMP; end
            2'b01: w_rd = 1'b1;
            2'b10: w_we = 1'b1;
            default: begin w_we = 1'b1; w_widx = r_random; end
          endcase
        end
      end
      S_PCMP:  w_state_next = S_DONE;
      S_DONE: begin
        op_done      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Only the valid bits are reset; the rest of each entry keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0 <= '0;
      r_v1 <= '0;
    end else if (w_we) begin
      r_v0[w_widx] <= c0_entrylo0[1];
      r_v1[w_widx] <= c0_entrylo1[1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      r_vpn2[w_widx] <= c0_entryhi[31:13];
      r_asid[w_widx] <= c0_entryhi[7:0];
      r_g[w_widx]    <= c0_entrylo0[0] & c0_entrylo1[0];
      r_pfn0[w_widx] <= c0_entrylo0[25:6];
      r_c0[w_widx]   <= c0_entrylo0[5:3];
      r_d0[w_widx]   <= c0_entrylo0[2];
      r_pfn1[w_widx] <= c0_entrylo1[25:6];
      r_c1[w_widx]   <= c0_entrylo1[5:3];
      r_d1[w_widx]   <= c0_entrylo1[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_probe_vpn2 <= '0;
      r_probe_asid <= '0;
      p_found      <= 1'b0;
      p_index      <= '0;
      r_entryhi    <= '0;
      r_entrylo0   <= '0;
      r_entrylo1   <= '0;
    end else begin
      if (w_probe) begin
        r_probe_vpn2 <= c0_entryhi[31:13];
        r_probe_asid <= c0_entryhi[7:0];
      end
      if (r_state == S_PCMP) begin
        p_found <= w_selp[IDXW];
        p_index <= w_selp[IDXW-1:0];
      end
      if (w_rd) begin
        r_entryhi  <= {r_vpn2[c0_index], 5'd0, r_asid[c0_index]};
        r_entrylo0 <= {6'd0, r_pfn0[c0_index], r_c0[c0_index], r_d0[c0_index],
                       r_v0[c0_index], r_g[c0_index]};
        r_entrylo1 <= {6'd0, r_pfn1[c0_index], r_c1[c0_index], r_d1[c0_index],
                       r_v1[c0_index], r_g[c0_index]};
      end
    end
  end

  // Random wraps to the top once it reaches Wired, so it never enters the wired range.
  always_ff @(posedge clk) begin
    if (reset || wired_we || r_random <= c0_wired) r_random <= IDXW'(TLBNUM - 1);
    else                                          r_random <= r_random - 1'b1;
  end

  assign random_index = r_random;

endmodule

// File: tb/tb_tlb_mmu_unit.sv
// Directed bench for tlb_mmu_unit: search ports, TLBP/TLBR/TLBWI/TLBWR,
// Random counter sequence, multi-hit priority and reset during a probe.
module tb_tlb_mmu_unit;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [18:0]     s0_vpn2 = '0, s1_vpn2 = '0;
  logic            s0_odd_page = 1'b0, s1_odd_page = 1'b0;
  logic            s0_found, s1_found;
  logic [IDXW-1:0] s0_index, s1_index;
  logic [19:0]     s0_pfn, s1_pfn;
  logic [2:0]      s0_c, s1_c;
  logic            s0_d, s0_v, s1_d, s1_v;
  logic            op_valid = 1'b0;
  logic [1:0]      op_code = 2'b00;
  logic            op_ready, op_done;
  logic [31:0]     c0_entryhi = '0, c0_entrylo0 = '0, c0_entrylo1 = '0;
  logic [IDXW-1:0] c0_index = '0, c0_wired = '0;
  logic            wired_we = 1'b0;
  logic            p_found;
  logic [IDXW-1:0] p_index;
  logic [31:0]     r_entryhi, r_entrylo0, r_entrylo1;
  logic [IDXW-1:0] random_index;

  int n_cmp = 0;
  int n_err = 0;

  tlb_mmu_unit #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_found(s0_found), .s0_index(s0_index),
    .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_found(s1_found), .s1_index(s1_index),
    .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
    .c0_entryhi(c0_entryhi), .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1),
    .c0_index(c0_index), .c0_wired(c0_wired), .wired_we(wired_we),
    .p_found(p_found), .p_index(p_index),
    .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
    .random_index(random_index)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation; lat = cycles from accept cycle to op_done cycle inclusive, -1 on timeout.
  task automatic do_op(input logic [1:0] code, output int lat);
    lat = -1;
    op_valid = 1'b1;
    op_code  = code;
    for (int w = 0; w < 10 && !op_ready; w++) step();
    step();
    op_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (op_done) begin
        lat = k + 1;
        break;
      end
      step();
    end
    $display("op code=%0d entryhi=%08h index=%0d latency=%0d", code, c0_entryhi, c0_index, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    s0_vpn2 = 19'h00001;
    #1;
    n_cmp++; if (s0_found !== 1'b0) begin n_err++; $display("FAIL rst_s0_found got=%0b exp=0", s0_found); end
    n_cmp++; if (s0_v !== 1'b0) begin n_err++; $display("FAIL rst_s0_v got=%0b exp=0", s0_v); end
    n_cmp++; if (random_index !== 4'd15) begin n_err++; $display("FAIL rst_random got=%0d exp=15", random_index); end
    n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rst_op_ready got=%0b exp=1", op_ready); end
    n_cmp++; if (op_done !== 1'b0) begin n_err++; $display("FAIL rst_op_done got=%0b exp=0", op_done); end
    n_cmp++; if (p_found !== 1'b0) begin n_err++; $display("FAIL rst_p_found got=%0b exp=0", p_found); end
    n_cmp++; if (r_entrylo0 !== 32'd0) begin n_err++; $display("FAIL rst_r_entrylo0 got=%08h exp=0", r_entrylo0); end
    $display("reset done");
  endtask

  task automatic test_tlbwi();
    int lat;
    c0_entryhi  = 32'h0000_2005;
    c0_entrylo0 = 32'h0000_0482;
    c0_entrylo1 = 32'h0000_0D00;
    c0_index    = 4'd3;
    do_op(2'b10, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wi_latency got=%0d exp=2", lat); end
    s1_vpn2 = 19'h00001; s1_odd_page = 1'b0; #1;
    n_cmp++; if (s1_found !== 1'b1) begin n_err++; $display("FAIL wi_s1_found got=%0b exp=1", s1_found); end
    n_cmp++; if (s1_index !== 4'd3) begin n_err++; $display("FAIL wi_s1_index got=%0d exp=3", s1_index); end
    n_cmp++; if (s1_pfn !== 20'h00012) begin n_err++; $display("FAIL wi_s1_pfn_even got=%05h exp=00012", s1_pfn); end
    n_cmp++; if (s1_v !== 1'b1) begin n_err++; $display("FAIL wi_s1_v_even got=%0b exp=1", s1_v); end
    s1_odd_page = 1'b1; #1;
    n_cmp++; if (s1_pfn !== 20'h00034) begin n_err++; $display("FAIL wi_s1_pfn_odd got=%05h exp=00034", s1_pfn); end
    n_cmp++; if (s1_v !== 1'b0) begin n_err++; $display("FAIL wi_s1_v_odd got=%0b exp=0", s1_v); end
    c0_entryhi = 32'h0000_2006; #1;
    n_cmp++; if (s1_found !== 1'b0) begin n_err++; $display("FAIL wi_asid_miss_found got=%0b exp=0", s1_found); end
    n_cmp++; if (s1_pfn !== 20'd0) begin n_err++; $display("FAIL wi_asid_miss_pfn got=%05h exp=0", s1_pfn); end
    c0_entryhi = 32'h0000_2005;
    s1_odd_page = 1'b0;
    step();
  endtask

  task automatic test_tlbp();
    int lat;
    c0_entryhi = 32'h0000_2005;
    do_op(2'b00, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL p_latency got=%0d exp=3", lat); end
    n_cmp++; if (p_found !== 1'b1) begin n_err++; $display("FAIL p_hit_found got=%0b exp=1", p_found); end
    n_cmp++; if (p_index !== 4'd3) begin n_err++; $display("FAIL p_hit_index got=%0d exp=3", p_index); end
    c0_entryhi = 32'hFFFF_E005;
    do_op(2'b00, lat);
    n_cmp++; if (p_found !== 1'b0) begin n_err++; $display("FAIL p_miss_found got=%0b exp=0", p_found); end
    n_cmp++; if (p_index !== 4'd0) begin n_err++; $display("FAIL p_miss_index got=%0d exp=0", p_index); end
    c0_entryhi = 32'h0000_2005;
    step();
  endtask

  task automatic test_tlbr();
    int lat;
    c0_index = 4'd3;
    do_op(2'b01, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL r_latency got=%0d exp=2", lat); end
    n_cmp++; if (r_entryhi !== 32'h0000_2005) begin n_err++; $display("FAIL r_entryhi got=%08h exp=00002005", r_entryhi); end
    n_cmp++; if (r_entrylo0 !== 32'h0000_0482) begin n_err++; $display("FAIL r_entrylo0 got=%08h exp=00000482", r_entrylo0); end
    n_cmp++; if (r_entrylo1 !== 32'h0000_0D00) begin n_err++; $display("FAIL r_entrylo1 got=%08h exp=00000d00", r_entrylo1); end
    step();
  endtask

  task automatic test_random_tlbwr();
    int lat;
    int seen;
    logic [IDXW-1:0] exp_rand;
    c0_wired = 4'd4;
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp_rand = (k == 12) ? 4'd15 : 4'(15 - k);
      n_cmp++; if (random_index !== exp_rand) begin n_err++; $display("FAIL rand_seq[%0d] got=%0d exp=%0d", k, random_index, exp_rand); end
      step();
    end
    $display("random sequence 15..4,15 checked");
    seen = 0;
    for (int w = 0; w < 40; w++) begin
      if (random_index == 4'd9) begin seen = 1; break; end
      step();
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL rand_reach9 got=%0d exp=1", seen); end
    c0_entryhi  = 32'h000A_A005;
    c0_entrylo0 = 32'h0000_2642;
    c0_entrylo1 = 32'h0000_0002;
    do_op(2'b11, lat);
    s0_vpn2 = 19'h00055; s0_odd_page = 1'b0; #1;
    n_cmp++; if (s0_found !== 1'b1) begin n_err++; $display("FAIL wr_found got=%0b exp=1", s0_found); end
    n_cmp++; if (s0_index !== 4'd9) begin n_err++; $display("FAIL wr_index got=%0d exp=9", s0_index); end
    n_cmp++; if (s0_pfn !== 20'h00099) begin n_err++; $display("FAIL wr_pfn got=%05h exp=00099", s0_pfn); end
    step();
  endtask

  task automatic test_multi_hit();
    int lat;
    c0_entryhi  = 32'h0157_8011;
    c0_entrylo0 = 32'h0000_1C03;
    c0_entrylo1 = 32'h0000_0001;
    c0_index    = 4'd7;
    do_op(2'b10, lat);
    c0_entrylo0 = 32'h0000_0803;
    c0_index    = 4'd2;
    do_op(2'b10, lat);
    c0_entryhi = 32'h0157_8022;
    s0_vpn2 = 19'h00ABC; s0_odd_page = 1'b0; #1;
    n_cmp++; if (s0_index !== 4'd2) begin n_err++; $display("FAIL multi_s0_index got=%0d exp=2", s0_index); end
    n_cmp++; if (s0_pfn !== 20'h00020) begin n_err++; $display("FAIL multi_s0_pfn got=%05h exp=00020", s0_pfn); end
    do_op(2'b00, lat);
    n_cmp++; if (p_found !== 1'b1) begin n_err++; $display("FAIL multi_p_found got=%0b exp=1", p_found); end
    n_cmp++; if (p_index !== 4'd2) begin n_err++; $display("FAIL multi_p_index got=%0d exp=2", p_index); end
    step();
  endtask

  task automatic test_reset_in_pcmp();
    int done_seen;
    c0_entryhi = 32'h0000_2005;
    op_code  = 2'b00;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    done_seen = 0;
    n_cmp++; if (random_index !== 4'd15) begin n_err++; $display("FAIL rstp_random got=%0d exp=15", random_index); end
    n_cmp++; if (p_found !== 1'b0) begin n_err++; $display("FAIL rstp_p_found got=%0b exp=0", p_found); end
    for (int k = 0; k < 4; k++) begin
      if (op_done) done_seen = 1;
      step();
    end
    n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL rstp_no_done got=%0d exp=0", done_seen); end
    n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rstp_op_ready got=%0b exp=1", op_ready); end
    s0_vpn2 = 19'h00001; s1_vpn2 = 19'h00ABC; s0_odd_page = 1'b0; s1_odd_page = 1'b0; #1;
    n_cmp++; if (s0_v !== 1'b0) begin n_err++; $display("FAIL rstp_s0_v got=%0b exp=0", s0_v); end
    n_cmp++; if (s1_v !== 1'b0) begin n_err++; $display("FAIL rstp_s1_v got=%0b exp=0", s1_v); end
    s0_vpn2 = 19'h00055; #1;
    n_cmp++; if (s0_v !== 1'b0) begin n_err++; $display("FAIL rstp_s0_v_e9 got=%0b exp=0", s0_v); end
    $display("reset during probe checked");
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbp();
    test_tlbr();
    test_random_tlbwr();
    test_multi_hit();
    test_reset_in_pcmp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
